// File: rtl/lcd_pkg.sv
// Shared constants for the character-LCD controller blocks.
// Holds the read-unit state encodings and the bus timing defaults, which are
// also the delay constants used by the main FSM.
package lcd_pkg;

  // Bus timing in 50 MHz clock cycles
  localparam int T_SETUP  = 2;   // RS/RW stable before E rises (>=40 ns)
  localparam int T_E_HIGH = 12;  // E high per nibble (>=230 ns)
  localparam int T_HOLD   = 1;   // RS/RW held after E falls (>=10 ns)
  localparam int T_GAP    = 50;  // between nibbles (>=1 us)

  localparam int PHASE_W  = 6;   // wide enough for T_GAP-1

  typedef enum logic [3:0] {
    RD_IDLE     = 4'd0,
    RD_SETUP_HI = 4'd1,
    RD_E_HI     = 4'd2,
    RD_HOLD_HI  = 4'd3,
    RD_GAP      = 4'd4,
    RD_SETUP_LO = 4'd5,
    RD_E_LO     = 4'd6,
    RD_HOLD_LO  = 4'd7,
    RD_DONE     = 4'd8
  } rd_state_t;

endpackage

// File: rtl/lcd_read_unit.sv
// lcd_read_unit: one 8-bit read from the character LCD over the 4-bit bus,
// upper nibble first, then lower nibble.
// Ports:
//   clk, reset       50 MHz clock, synchronous active-high reset
//   rd_req, rd_rs    start request and register select (sampled in IDLE only)
//   sf_d_in[3:0]     data nibble from the pad
//   rd_busy          high in every state except IDLE
//   rd_done          one-cycle pulse; rd_data valid from this cycle on
//   rd_data[7:0]     assembled {hi,lo} byte, held until the next completed read
//   bus_own          top level tristates SF_D and muxes controls to this block
//   LCD_E/RS/RW      LCD control strobes
module lcd_read_unit
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic [3:0] sf_d_in,
  output logic       rd_busy,
  output logic       rd_done,
  output logic [7:0] rd_data,
  output logic       bus_own,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(T_SETUP - 1);
  localparam logic [PHASE_W-1:0] E_LAST     = PHASE_W'(T_E_HIGH - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(T_HOLD - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(T_GAP - 1);

  rd_state_t          state, state_n;
  logic [PHASE_W-1:0] phase;
  logic               timed, phase_end;
  logic               rs_q;
  logic [3:0]         hi_q;

  // Which states are timed and when their phase runs out
  always_comb begin
    timed     = 1'b0;
    phase_end = 1'b0;
    case (state)
      RD_SETUP_HI, RD_SETUP_LO: begin timed = 1'b1; phase_end = (phase == SETUP_LAST); end
      RD_E_HI, RD_E_LO:         begin timed = 1'b1; phase_end = (phase == E_LAST);     end
      RD_HOLD_HI, RD_HOLD_LO:   begin timed = 1'b1; phase_end = (phase == HOLD_LAST);  end
      RD_GAP:                   begin timed = 1'b1; phase_end = (phase == GAP_LAST);   end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RD_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_n = state;
    case (state)
      RD_IDLE:     if (rd_req)    state_n = RD_SETUP_HI;
      RD_SETUP_HI: if (phase_end) state_n = RD_E_HI;
      RD_E_HI:     if (phase_end) state_n = RD_HOLD_HI;
      RD_HOLD_HI:  if (phase_end) state_n = RD_GAP;
      RD_GAP:      if (phase_end) state_n = RD_SETUP_LO;
      RD_SETUP_LO: if (phase_end) state_n = RD_E_LO;
      RD_E_LO:     if (phase_end) state_n = RD_HOLD_LO;
      RD_HOLD_LO:  if (phase_end) state_n = RD_DONE;
      RD_DONE:                    state_n = RD_IDLE;
      default:                    state_n = RD_IDLE;
    endcase
  end

  // Shared phase counter: restarts on each state change, idles at 0
  always_ff @(posedge clk) begin
    if (reset)                 phase <= '0;
    else if (state_n != state) phase <= '0;
    else if (timed)            phase <= phase + 1'b1;
    else                       phase <= '0;
  end

  // Datapath: rd_data is written once, whole, so it never shows half a byte
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q    <= 1'b0;
      hi_q    <= 4'h0;
      rd_data <= 8'h00;
    end else begin
      if (state == RD_IDLE && rd_req) rs_q    <= rd_rs;
      if (state == RD_E_HI && phase_end) hi_q <= sf_d_in;
      if (state == RD_E_LO && phase_end) rd_data <= {hi_q, sf_d_in};
    end
  end

  // Moore outputs
  always_comb begin
    rd_busy = 1'b0;
    rd_done = 1'b0;
    LCD_E   = 1'b0;
    case (state)
      RD_SETUP_HI, RD_HOLD_HI, RD_GAP, RD_SETUP_LO, RD_HOLD_LO: rd_busy = 1'b1;
      RD_E_HI, RD_E_LO: begin rd_busy = 1'b1; LCD_E = 1'b1; end
      RD_DONE:          begin rd_busy = 1'b1; rd_done = 1'b1; end
      default: ;
    endcase
    bus_own = rd_busy;
    LCD_RW  = rd_busy;
    LCD_RS  = rd_busy & rs_q;
  end

endmodule

// File: tb/tb_lcd_read_unit.sv
// Bench for lcd_read_unit. The reference model tracks a transaction as a
// cycle offset (1..81) from acceptance and derives every output from it.
module tb_lcd_read_unit;

  logic       clk = 1'b0;
  logic       reset, rd_req, rd_rs;
  logic [3:0] sf_d_in;
  logic       rd_busy, rd_done, bus_own, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] rd_data;

  lcd_read_unit dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_rs(rd_rs), .sf_d_in(sf_d_in),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_data(rd_data), .bus_own(bus_own),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: off=0 idle, 1..80 timed phases, 81 done
  int         off = 0;
  logic       m_rs = 1'b0;
  logic [3:0] m_hi = 4'h0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] tgt = 8'h00, next_tgt = 8'h00;

  int cyc = 0, start_cyc = 0, rise_cyc = 0, fall_cyc = 0, last_done = -1;
  int e_rises = 0, done_cnt = 0;
  bit chk_timing = 1'b0, chk_period = 1'b0;
  logic prev_e = 1'b0;

  task automatic cycle();
    logic        exp_e, busy;
    logic [13:0] ev, ov;
    @(posedge clk); #1;
    cyc++;
    // advance model with the inputs that were present at this edge
    if (reset) begin
      off = 0; m_rs = 1'b0; m_hi = 4'h0; m_data = 8'h00;
    end else if (off == 0) begin
      if (rd_req) begin
        off = 1; m_rs = rd_rs; start_cyc = cyc; e_rises = 0;
        tgt = next_tgt; next_tgt = 8'($urandom);
      end
    end else begin
      if (off == 14) m_hi = sf_d_in;
      if (off == 79) m_data = {m_hi, sf_d_in};
      off = (off == 81) ? 0 : off + 1;
    end
    busy  = (off != 0);
    exp_e = (off >= 3 && off <= 14) || (off >= 68 && off <= 79);
    ev = {busy, off == 81, busy, exp_e, busy & m_rs, busy, m_data};
    ov = {rd_busy, rd_done, bus_own, LCD_E, LCD_RS, LCD_RW, rd_data};
    chk("outputs", 32'(ov), 32'(ev));

    // direct measurements of the strobe from the DUT pins
    if (LCD_E && !prev_e) begin
      if (e_rises == 1) chk("e_gap", 32'(cyc - fall_cyc), 32'd53);
      e_rises++;
      rise_cyc = cyc;
    end
    if (!LCD_E && prev_e) begin
      if (chk_timing) chk("e_width", 32'(cyc - rise_cyc), 32'd12);
      fall_cyc = cyc;
    end
    if (rd_done) begin
      chk("done_lat", 32'(cyc - start_cyc), 32'd80);
      chk("e_pulses", 32'(e_rises), 32'd2);
      chk("data", 32'(rd_data), 32'(tgt));
      if (chk_period && last_done >= 0) chk("period", 32'(cyc - last_done), 32'd82);
      last_done = cyc;
      done_cnt++;
    end
    prev_e = LCD_E;

    // valid nibble only at the sample edges, garbage otherwise
    if (off == 14)      sf_d_in = tgt[7:4];
    else if (off == 79) sf_d_in = tgt[3:0];
    else                sf_d_in = 4'($urandom);
  endtask

  task automatic run_read(input logic rs, input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    next_tgt = b;
    rd_req = 1'b1; rd_rs = rs;
    cycle();
    rd_req = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      rd_rs = 1'($urandom);
      cycle();
      if (rd_done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    cycle();
  endtask

  initial begin
    int d0;
    reset = 1'b1; rd_req = 1'b0; rd_rs = 1'b0; sf_d_in = 4'h0;

    // 1: reset then quiet idle
    repeat (3) cycle();
    chk("reset_out", 32'({rd_busy, rd_done, bus_own, LCD_E, LCD_RS, LCD_RW, rd_data}), 32'd0);
    reset = 1'b0;
    repeat (100) begin rd_rs = 1'($urandom); cycle(); end
    chk("idle_out", 32'({rd_busy, rd_done, bus_own, LCD_E, LCD_RS, LCD_RW, rd_data}), 32'd0);

    // 2: status read, 0x85
    chk_timing = 1'b1;
    run_read(1'b0, 8'h85);
    chk("rd_85", 32'(rd_data), 32'h85);

    // 3: data read, 0x4B
    run_read(1'b1, 8'h4B);
    chk("rd_4b", 32'(rd_data), 32'h4B);

    // 4: request held high -> back-to-back reads
    chk_period = 1'b1; last_done = -1;
    d0 = done_cnt;
    rd_req = 1'b1;
    for (int i = 0; i < 400 && done_cnt < d0 + 3; i++) begin
      rd_rs = 1'($urandom);
      cycle();
    end
    rd_req = 1'b0;
    chk("b2b_count", 32'(done_cnt - d0), 32'd3);
    chk_period = 1'b0;
    repeat (90) cycle();

    // 5: reset on the 5th cycle of E_LO
    chk_timing = 1'b0;
    next_tgt = 8'hA7;
    rd_req = 1'b1; rd_rs = 1'b1;
    cycle();
    rd_req = 1'b0;
    for (int i = 0; i < 100 && off != 72; i++) cycle();
    chk("reached_elo", 32'(off), 32'd72);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_e", 32'(LCD_E), 32'd0);
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    d0 = done_cnt;
    repeat (90) cycle();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

    // 6: random reads with garbage between sample edges
    chk_timing = 1'b1;
    repeat (6) run_read(1'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
